// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan: value/load request in, scan outputs and status back.
interface seg_scan_if;
    logic [15:0] value;
    logic        load;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        ack;
    logic        busy;

    modport master (output value, load, input nibble, an, ack, busy);
    modport slave  (input value, load, output nibble, an, ack, busy);
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with shadowed, frame-aligned value updates.
// Optional build macro SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan #(
    parameter int DIV   = 50000,
    parameter int GUARD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    seg_scan_if.slave   bus
);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t      state, state_nx;
    logic [15:0] presc;
    logic [1:0]  idx;
    logic [15:0] disp_reg;
    logic [15:0] shadow;
    logic        busy;
    logic        ack;
    logic        slot_end;
    logic        frame_end;
    logic        commit;
    logic        blank;
    logic [3:0]  an;
    logic [3:0]  nibble;

`ifdef SEG_SCAN_LZ_BLANK_EN
    function automatic logic upper_zero(input logic [15:0] d, input logic [1:0] i);
        logic [15:0] s;
        s = d >> {i, 2'b00};
        return (s == 16'h0000);
    endfunction
`endif

    assign slot_end  = (presc == 16'(DIV - 1));
    assign frame_end = slot_end && (idx == 2'd3);
    // Commit only at the last cycle of a frame so the display never changes mid-frame.
    assign commit    = (state == SHOW) && frame_end && busy;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.load) state_nx = SHOW;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc    <= '0;
            idx      <= '0;
            disp_reg <= '0;
            shadow   <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (state == IDLE) begin
                presc <= '0;
                idx   <= '0;
                if (bus.load) begin
                    disp_reg <= bus.value;
                    ack      <= 1'b1;
                end
            end else begin
                presc <= slot_end ? 16'd0 : presc + 16'd1;
                if (slot_end) idx <= idx + 2'd1;
                // A load coinciding with the commit bypasses the shadow: latest value wins.
                if (commit) begin
                    disp_reg <= bus.load ? bus.value : shadow;
                    busy     <= 1'b0;
                    ack      <= 1'b1;
                end else if (bus.load) begin
                    shadow <= bus.value;
                    busy   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        an     = 4'b1111;
        nibble = 4'h0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        blank  = (idx != 2'd0) && upper_zero(disp_reg, idx);
`else
        blank  = 1'b0;
`endif
        if (state == SHOW) begin
            nibble = disp_reg[{idx, 2'b00} +: 4];
            if (presc >= 16'(GUARD) && !blank) an = ~(4'b0001 << idx);
        end
    end

    assign bus.an     = an;
    assign bus.nibble = nibble;
    assign bus.ack    = ack;
    assign bus.busy   = busy;

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot; legal range 4..65535.
REQ-002 Parameter GUARD, default 2: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1..DIV-1.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 value  input  16  four hex digits to display; value[3:0] is digit 0 (rightmost).
REQ-006 load  input  1  one-cycle request to capture value.
REQ-007 nibble  output  4  hex digit currently scanned; feeds the in port of the 7-segment decoder.
REQ-008 an  output  4  digit anodes, active-low, at most one low at any time.
REQ-009 ack  output  1  one-cycle pulse when a captured value becomes the displayed value.
REQ-010 busy  output  1  high while a captured value waits to be committed.

Function
REQ-011 State machine has 2 states: IDLE (nothing displayed yet) and SHOW (scanning).
REQ-012 IDLE, load=1: value is written directly to the display register, ack=1 on the next cycle, state becomes SHOW, and prescaler and digit index start at 0.
REQ-013 SHOW: the prescaler counts 0..DIV-1 and wraps; on the wrap cycle the digit index advances 0->1->2->3->0.
REQ-014 SHOW: an is low for the current digit only when prescaler >= GUARD; otherwise an=4'b1111.
REQ-015 nibble = display_reg[4*idx+3 : 4*idx]; an and nibble are combinational from registered state with no extra latency.
REQ-016 SHOW, load=1: value goes to a shadow register and busy=1; a second load before commit overwrites the shadow (latest wins), and only one ack results.
REQ-017 Commit occurs on the cycle where prescaler=DIV-1, idx=3 and busy=1: the shadow is copied to the display register, busy drops, and ack pulses on the next cycle; the new value appears at the start of the next frame (idx=0).
REQ-018 load on the same cycle as a commit: the input value is committed directly, bypassing the shadow; busy=0 afterwards and exactly one ack is produced.
REQ-019 load while busy=0 with no pending commit follows REQ-016; the display is never updated mid-frame.
REQ-020 IDLE: an=4'b1111, nibble=0, and the prescaler is held at 0.

Reset
REQ-021 rst_n=0 sampled at a clock edge forces: state=IDLE, prescaler=0, idx=0, display_reg=0, shadow=0, busy=0, ack=0, an=4'b1111, nibble=0.
REQ-022 Reset mid-frame or while busy=1 discards the pending value; no ack is issued for it.
REQ-023 load is ignored in any cycle where rst_n=0.

Configuration
REQ-024 Macro SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking.
REQ-025 With SEG_SCAN_LZ_BLANK_EN defined: for idx>=1, an stays 4'b1111 through the whole slot if display_reg digits idx..3 are all zero; digit 0 is always shown, so value 0 shows a single "0".
REQ-026 Without SEG_SCAN_LZ_BLANK_EN: all four digits are shown in every frame; scan timing is identical in both builds.

Verification (DIV=4, GUARD=1)
REQ-027 Reset, then hold 20 cycles with no load -> an=4'b1111, nibble=0, ack=0, busy=0 throughout.
REQ-028 IDLE, load with value=16'h1A2F -> ack one cycle later; per slot, nibble is F,2,A,1 with an pattern 1111 for 1 cycle then 1110/1101/1011/0111 for 3 cycles each; the frame repeats every 16 cycles.
REQ-029 SHOW mid-frame, load 16'h0005 then load 16'h0007 two cycles later -> busy=1 until the idx=3 wrap, exactly one ack, and the next frame shows 7,0,0,0.
REQ-030 load 16'hBEEF on the commit cycle while the shadow holds 16'h1111 -> the next frame shows F,E,E,B, busy=0, one ack.
REQ-031 busy=1, assert rst_n=0 for 1 cycle -> IDLE with an=4'b1111 and no ack; a following load behaves per REQ-012.
REQ-032 SEG_SCAN_LZ_BLANK_EN build, value 16'h0030 -> digits 0 and 1 active and digits 2 and 3 dark; value 16'h0000 -> only digit 0 active, showing nibble 0.
